pc_redirect_arb: RTL

- Arbitrates every PC-redirect source onto the single prefetch-unit (PFU) PC write port: boot vector, execute-stage trap, external interrupt and execute-stage jump.
- Computes the trap/interrupt target from mtvec and emits a trap-taken strobe to the CSR unit.
- Holds one pending redirect while the PFU is not ready. The front end is the only consumer of pfu_pc_o.

---
 rtl/redirect_pkg.sv | 24 ++
 rtl/redirect_tgt_calc.sv | 49 ++++
 rtl/pc_redirect_arb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/redirect_pkg.sv
// Shared definitions for the PC redirect arbiter.
//   kind_e  : redirect request class; numeric order equals priority, so a
//             plain >= compare decides whether one request outranks another.
//   state_e : arbiter state encodings.
//   MTVEC_MODE_* : mtvec[1:0] mode values.
package redirect_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_JUMP = 2'd1,
    KIND_IRQ  = 2'd2,
    KIND_TRAP = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    STATE_BOOT = 2'd0,
    STATE_IDLE = 2'd1,
    STATE_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/redirect_tgt_calc.sv
// Combinational redirect target computation.
// Optional feature macro: REDIRECT_VECTORED_EN (vectored interrupt offsets).
// Ports:
//   kind_i       request class selecting the target source
//   jump_addr_i  jump/branch target
//   mtvec_i      mtvec CSR: base [XLEN-1:2], mode [1:0]
//   irq_cause_i  interrupt cause, used for the vectored offset
//   tgt_o        selected target address
module redirect_tgt_calc
  import redirect_pkg::*;
#(
  parameter int unsigned C_XLEN    = 32,
  parameter int unsigned C_CAUSE_W = 5
) (
  input  kind_e               kind_i,
  input  logic [C_XLEN-1:0]   jump_addr_i,
  input  logic [C_XLEN-1:0]   mtvec_i,
  input  logic [C_CAUSE_W-1:0] irq_cause_i,
  output logic [C_XLEN-1:0]   tgt_o
);

  logic [C_XLEN-1:0] base;
  logic [C_XLEN-1:0] irq_tgt;

  assign base = {mtvec_i[C_XLEN-1:2], 2'b00};

`ifdef REDIRECT_VECTORED_EN
  logic [C_XLEN-1:0] vec_off;

  assign vec_off = C_XLEN'(irq_cause_i) << 2;
  // Only mode 01 is vectored; 1x modes fall back to direct.
  assign irq_tgt = (mtvec_i[1:0] == MTVEC_MODE_VECTORED) ? (base + vec_off) : base;
`else
  logic unused_vec;

  assign unused_vec = ^{irq_cause_i, mtvec_i[1:0]};
  assign irq_tgt    = base;
`endif

  always_comb begin
    tgt_o = jump_addr_i;
    case (kind_i)
      KIND_TRAP: tgt_o = base;
      KIND_IRQ:  tgt_o = irq_tgt;
      default:   tgt_o = jump_addr_i;
    endcase
  end

endmodule

// File: rtl/pc_redirect_arb.sv
// PC redirect arbiter: selects boot vector, trap, interrupt or jump onto the
// single PFU PC write port, holding one pending redirect while the PFU stalls.
// Optional feature macro: REDIRECT_VECTORED_EN (see redirect_tgt_calc).
// Ports:
//   clk_i, resetb_i (sync active-low), clk_en_i (global enable)
//   pfu_pc_ready_i / pfu_pc_wr_o / pfu_pc_o : PFU PC write port
//   exs_jump_i, exs_jump_addr_i             : jump request
//   exs_trap_i, exs_trap_cause_i            : synchronous exception
//   irq_i, irq_en_i, irq_cause_i            : external interrupt
//   csr_mtvec_i                             : trap vector base/mode
//   trap_taken_o, trap_irq_o, trap_cause_o  : trap acceptance to CSR unit
//   flush_o                                 : redirect accepted this cycle
//   busy_o                                  : redirect pending (BOOT/WAIT)
module pc_redirect_arb
  import redirect_pkg::*;
#(
  parameter int unsigned       C_XLEN         = 32,
  parameter int unsigned       C_CAUSE_W      = 5,
  parameter logic [C_XLEN-1:0] C_RESET_VECTOR = '0
) (
  input  logic                 clk_i,
  input  logic                 resetb_i,
  input  logic                 clk_en_i,
  input  logic                 pfu_pc_ready_i,
  output logic                 pfu_pc_wr_o,
  output logic [C_XLEN-1:0]    pfu_pc_o,
  input  logic                 exs_jump_i,
  input  logic [C_XLEN-1:0]    exs_jump_addr_i,
  input  logic                 exs_trap_i,
  input  logic [C_CAUSE_W-1:0] exs_trap_cause_i,
  input  logic                 irq_i,
  input  logic                 irq_en_i,
  input  logic [C_CAUSE_W-1:0] irq_cause_i,
  input  logic [C_XLEN-1:0]    csr_mtvec_i,
  output logic                 trap_taken_o,
  output logic                 trap_irq_o,
  output logic [C_CAUSE_W-1:0] trap_cause_o,
  output logic                 flush_o,
  output logic                 busy_o
);

  state_e            state_q, state_d;
  kind_e             pend_kind_q;
  logic [C_XLEN-1:0] pend_tgt_q;
  kind_e             req_kind;
  logic [C_XLEN-1:0] req_tgt;
  logic              active;
  logic              accept;
  logic              pend_ld;

  always_comb begin
    req_kind = KIND_NONE;
    if (exs_trap_i)            req_kind = KIND_TRAP;
    else if (irq_i && irq_en_i) req_kind = KIND_IRQ;
    else if (exs_jump_i)       req_kind = KIND_JUMP;
  end

  redirect_tgt_calc #(
    .C_XLEN    (C_XLEN),
    .C_CAUSE_W (C_CAUSE_W)
  ) u_tgt_calc (
    .kind_i      (req_kind),
    .jump_addr_i (exs_jump_addr_i),
    .mtvec_i     (csr_mtvec_i),
    .irq_cause_i (irq_cause_i),
    .tgt_o       (req_tgt)
  );

  // Strobes are gated by reset as well as enable, since reset is synchronous
  // and the state register may still hold a live state during the reset cycle.
  assign active = resetb_i & clk_en_i;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    pend_ld     = 1'b0;
    pfu_pc_wr_o = 1'b0;
    pfu_pc_o    = pend_tgt_q;
    busy_o      = (state_q != STATE_IDLE);
    case (state_q)
      STATE_BOOT: begin
        pfu_pc_o = C_RESET_VECTOR;
        if (active && pfu_pc_ready_i) begin
          pfu_pc_wr_o = 1'b1;
          state_d     = STATE_IDLE;
        end
      end
      STATE_IDLE: begin
        pfu_pc_o = req_tgt;
        if (active && (req_kind != KIND_NONE)) begin
          accept = 1'b1;
          if (pfu_pc_ready_i) begin
            pfu_pc_wr_o = 1'b1;
          end else begin
            pend_ld = 1'b1;
            state_d = STATE_WAIT;
          end
        end
      end
      STATE_WAIT: begin
        // Equal-or-higher priority replaces the pending redirect; a
        // simultaneous ready writes the new target straight through.
        if (active && (req_kind != KIND_NONE) && (req_kind >= pend_kind_q)) begin
          accept   = 1'b1;
          pfu_pc_o = req_tgt;
          if (pfu_pc_ready_i) begin
            pfu_pc_wr_o = 1'b1;
            state_d     = STATE_IDLE;
          end else begin
            pend_ld = 1'b1;
          end
        end else if (active && pfu_pc_ready_i) begin
          pfu_pc_wr_o = 1'b1;
          state_d     = STATE_IDLE;
        end
      end
      default: state_d = STATE_BOOT;
    endcase
  end

  assign flush_o      = accept;
  assign trap_taken_o = accept && (req_kind >= KIND_IRQ);
  assign trap_irq_o   = accept && (req_kind == KIND_IRQ);

  always_comb begin
    trap_cause_o = '0;
    if (trap_taken_o) begin
      trap_cause_o = (req_kind == KIND_IRQ) ? irq_cause_i : exs_trap_cause_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_q <= STATE_BOOT;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pend_ld) begin
      pend_kind_q <= req_kind;
      pend_tgt_q  <= req_tgt;
    end
  end

endmodule
